// File: rtl/win_screen_ctrl_if.sv
// Signal bundle between the game logic / VGA timing and the win-screen controller.
// The master side drives sync, mate and button levels; the slave side
// (the controller) drives the overlay flags and the game control outputs.
interface win_screen_ctrl_if;
  logic vsync;
  logic white_mate;
  logic black_mate;
  logic restart_btn;
  logic white_win;
  logic black_win;
  logic game_active;
  logic new_game;

  modport master (
    output vsync, white_mate, black_mate, restart_btn,
    input  white_win, black_win, game_active, new_game
  );

  modport slave (
    input  vsync, white_mate, black_mate, restart_btn,
    output white_win, black_win, game_active, new_game
  );
endinterface

// File: rtl/win_screen_ctrl.sv
// Win-screen sequencer: latches the winner on checkmate, blinks the winner
// flag for BLINK_COUNT on/off cycles of BLINK_FRAMES frames each, holds it
// steady for HOLD_FRAMES frames, then waits for a fresh restart press and
// issues a one-clock new_game pulse.
module win_screen_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_COUNT  = 3,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic clk,
  input  logic rst,
  win_screen_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] BLINK_ON  = 3'd1;
  localparam logic [2:0] BLINK_OFF = 3'd2;
  localparam logic [2:0] HOLD      = 3'd3;
  localparam logic [2:0] WAIT_BTN  = 3'd4;
  localparam logic [2:0] CLEAR     = 3'd5;

  localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
  localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [3:0] COUNT_LAST = 4'(BLINK_COUNT - 1);

  logic [2:0] state, state_nxt;
  logic [9:0] frame_cnt, frame_nxt;
  logic [3:0] blink_cnt, blink_nxt;
  logic       winner_white, winner_nxt;
  logic       vsync_q, btn_q;
  logic       frame_tick, btn_rise, show_flag;
  logic       white_win_q, black_win_q, game_active_q, new_game_q;

  assign frame_tick = bus.vsync & ~vsync_q;
  assign btn_rise   = bus.restart_btn & ~btn_q;

  // Next-state, counter and winner-latch logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt  = state;
    frame_nxt  = frame_cnt;
    blink_nxt  = blink_cnt;
    winner_nxt = winner_white;
    case (state)
      IDLE: begin
        if (bus.white_mate || bus.black_mate) begin
          winner_nxt = bus.white_mate;  // white wins a tie
          frame_nxt  = '0;
          blink_nxt  = '0;
          state_nxt  = BLINK_ON;
        end
      end
      BLINK_ON: begin
        if (frame_tick) begin
          if (frame_cnt == BLINK_LAST) begin
            frame_nxt = '0;
            state_nxt = BLINK_OFF;
          end else begin
            frame_nxt = frame_cnt + 10'd1;
          end
        end
      end
      BLINK_OFF: begin
        if (frame_tick) begin
          if (frame_cnt == BLINK_LAST) begin
            frame_nxt = '0;
            if (blink_cnt == COUNT_LAST) begin
              state_nxt = HOLD;
            end else begin
              blink_nxt = blink_cnt + 4'd1;
              state_nxt = BLINK_ON;
            end
          end else begin
            frame_nxt = frame_cnt + 10'd1;
          end
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (frame_cnt == HOLD_LAST) begin
            frame_nxt = '0;
            state_nxt = WAIT_BTN;
          end else begin
            frame_nxt = frame_cnt + 10'd1;
          end
        end
      end
      WAIT_BTN: begin
        // btn_q tracks the button in every state, so a button already held
        // on entry produces no rising edge here.
        if (btn_rise) state_nxt = CLEAR;
      end
      CLEAR: begin
        winner_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Winner flag is visible in the "on" states only; loser flag never.
  assign show_flag = (state_nxt == BLINK_ON) || (state_nxt == HOLD) ||
                     (state_nxt == WAIT_BTN);

  // State, counters, edge registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      blink_cnt     <= '0;
      winner_white  <= 1'b0;
      vsync_q       <= 1'b0;
      btn_q         <= 1'b0;
      white_win_q   <= 1'b0;
      black_win_q   <= 1'b0;
      game_active_q <= 1'b1;
      new_game_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state         <= state_nxt;
      frame_cnt     <= frame_nxt;
      blink_cnt     <= blink_nxt;
      winner_white  <= winner_nxt;
      vsync_q       <= bus.vsync;
      btn_q         <= bus.restart_btn;
      white_win_q   <= show_flag & winner_nxt;
      black_win_q   <= show_flag & ~winner_nxt;
      game_active_q <= (state_nxt == IDLE);
      new_game_q    <= (state_nxt == CLEAR);
    end
  end

  assign bus.white_win   = white_win_q;
  assign bus.black_win   = black_win_q;
  assign bus.game_active = game_active_q;
  assign bus.new_game    = new_game_q;

endmodule

// File: doc/win_screen_ctrl.md
WIN_SCREEN_CTRL -- requirements
Module: win_screen_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period, range 1..1023.
REQ-002 SHALL have parameter BLINK_COUNT, default 3, on/off blink cycles before steady display, range 1..15.
REQ-003 SHALL have parameter HOLD_FRAMES, default 180, frames of steady display before restart is accepted, range 1..1023.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all logic on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port vsync  input  1  VGA vertical sync; rising edge marks one frame.
REQ-007 SHALL have port white_mate  input  1  game logic: white has won; level, sampled each clk.
REQ-008 SHALL have port black_mate  input  1  game logic: black has won; level, sampled each clk.
REQ-009 SHALL have port restart_btn  input  1  debounced restart button, level.
REQ-010 SHALL have port white_win  output  1  drives the overlay white-winner flag.
REQ-011 SHALL have port black_win  output  1  drives the overlay black-winner flag.
REQ-012 SHALL have port game_active  output  1  high while moves are accepted.
REQ-013 SHALL have port new_game  output  1  one-clk pulse requesting board re-initialisation.

Function
REQ-014 SHALL register all outputs; no combinational path from input to output.
REQ-015 SHALL derive frame_tick as a one-clk pulse on vsync 0->1, using a registered copy of vsync.
REQ-016 SHALL implement states IDLE, BLINK_ON, BLINK_OFF, HOLD, WAIT_BTN, CLEAR.
REQ-017 IDLE: game_active=1, white_win=black_win=0, new_game=0.
REQ-018 IDLE: on white_mate|black_mate, latch winner (white if white_mate, else black), clear frame and blink counters, enter BLINK_ON.
REQ-019 Both mate inputs high in the same cycle SHALL latch white (white priority).
REQ-020 Outputs SHALL change one clk after the mate input is sampled: game_active=0 and the winner flag=1.
REQ-021 Mate inputs SHALL be ignored in every state except IDLE; the latched winner is held until CLEAR.
REQ-022 BLINK_ON: winner flag=1; after BLINK_FRAMES frame_ticks, clear frame counter and enter BLINK_OFF.
REQ-023 BLINK_OFF: both flags=0; after BLINK_FRAMES frame_ticks, if blink counter == BLINK_COUNT-1 enter HOLD, else increment blink counter and enter BLINK_ON.
REQ-024 HOLD: winner flag=1 steady; restart_btn ignored; after HOLD_FRAMES frame_ticks enter WAIT_BTN.
REQ-025 WAIT_BTN: winner flag=1; on a restart_btn 0->1 edge (registered previous value) enter CLEAR; a button already held on entry SHALL NOT trigger.
REQ-026 CLEAR: new_game=1 for exactly one clk, flags=0, game_active=0; next state IDLE, where game_active=1.
REQ-027 The loser flag SHALL be 0 in every state; white_win and black_win SHALL never both be 1.
REQ-028 Frame counter SHALL be 10 bits and blink counter 4 bits; each compares with equality against (parameter-1) on frame_tick and SHALL NOT wrap inside a state.
REQ-029 A frame_tick in the same cycle as the state entry SHALL NOT be counted; counting starts from the cycle after entry.
REQ-030 Restart edges during BLINK_ON, BLINK_OFF or HOLD SHALL be discarded, not queued.

Reset
REQ-031 While rst=1, state SHALL be IDLE, all counters, the winner latch and edge registers 0, white_win=black_win=new_game=0, and game_active=1, independent of clk.
REQ-032 Assertion of rst mid-sequence SHALL abort the sequence without a new_game pulse; after release the block SHALL behave as from power-up.

Verification (BLINK_FRAMES=2, BLINK_COUNT=2, HOLD_FRAMES=3)
REQ-033 white_mate pulse in IDLE -> next clk white_win=1, game_active=0; white_win sequence per frame 1,1,0,0,1,1,0,0, then steady 1 for 3 frames, then WAIT_BTN.
REQ-034 white_mate and black_mate high in the same clk -> white_win follows REQ-033; black_win stays 0 throughout.
REQ-035 restart_btn pulsed during blink and HOLD -> no new_game; held high across the WAIT_BTN entry -> no new_game until released and pressed again; then exactly one new_game clk, then game_active=1 and flags 0.
REQ-036 black_mate in IDLE, then white_mate during BLINK_ON -> only black_win ever asserts; winner unchanged through CLEAR.
REQ-037 rst asserted asynchronously mid-BLINK_OFF -> outputs go to reset values before the next clk edge; no new_game pulse; a fresh mate after release restarts the sequence from the first blink.
